// File: rtl/slave_port_if.sv
// Serial-bus and local-memory signal bundle for slave_port; the slave modport is the endpoint's view,
// the master modport is the view of whatever drives the serial bus and models the memory.
interface slave_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  swdata;
    logic                  smode;
    logic                  mvalid;
    logic                  srdata;
    logic                  svalid;
    logic [ADDR_WIDTH-1:0] daddr;
    logic [DATA_WIDTH-1:0] dwdata;
    logic                  dwen;
    logic                  dren;
    logic [DATA_WIDTH-1:0] drdata;
    logic                  drvalid;
    logic                  busy;
    logic                  dtimeout;

    modport slave (
        input  swdata, smode, mvalid, drdata, drvalid,
        output srdata, svalid, daddr, dwdata, dwen, dren, busy, dtimeout
    );

    modport master (
        output swdata, smode, mvalid, drdata, drvalid,
        input  srdata, svalid, daddr, dwdata, dwen, dren, busy, dtimeout
    );
endinterface

// File: rtl/slave_port.sv
// Serial-bus slave endpoint: deserialises LSB-first address/write data, strobes local memory, serialises read data back.
// Optional read timeout enabled by defining SLAVE_PORT_TIMEOUT_EN (loads all-ones data after RD_TIMEOUT MEMRD cycles).
module slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    slave_port_if.slave  bus
);
    localparam int MAXW   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W  = $clog2(MAXW) + 1;
    localparam int AIDX_W = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int DIDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    if (ADDR_WIDTH < 2 || DATA_WIDTH < 2 || RD_TIMEOUT < 1) begin : g_bad_cfg
        $error("slave_port: ADDR_WIDTH/DATA_WIDTH must be >= 2 and RD_TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MEMRD,
        RDATA
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_daddr;
    logic [DATA_WIDTH-1:0] r_dwdata;
    logic [DATA_WIDTH-1:0] r_rdat;
    logic                  r_dwen;
    logic                  r_dren;
    logic                  r_dto;
    logic                  w_dwen_nxt;
    logic                  w_dren_nxt;
    logic                  w_dto_nxt;
    logic                  w_addr_we;
    logic                  w_wdat_we;
    logic                  w_rdat_ld;
    logic                  w_rdat_ones;
    logic                  w_expire;
    logic [AIDX_W-1:0]     w_aidx;
    logic [DIDX_W-1:0]     w_didx;

    assign w_aidx = r_cnt[AIDX_W-1:0];
    assign w_didx = r_cnt[DIDX_W-1:0];

`ifdef SLAVE_PORT_TIMEOUT_EN
    localparam int TO_W = $clog2(RD_TIMEOUT + 1);
    logic [TO_W-1:0] r_tcnt;

    // r_tcnt is the index of the current MEMRD cycle, the dren cycle being 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state != MEMRD) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign w_expire = (r_tcnt == TO_W'(RD_TIMEOUT - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Every path back to IDLE clears the counter, so IDLE always shifts into bit 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dwen_nxt  = 1'b0;
        w_dren_nxt  = 1'b0;
        w_dto_nxt   = 1'b0;
        w_addr_we   = 1'b0;
        w_wdat_we   = 1'b0;
        w_rdat_ld   = 1'b0;
        w_rdat_ones = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mvalid) begin
                    w_addr_we   = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (!bus.mvalid) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_addr_we = 1'b1;
                    if (r_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                        w_cnt_nxt = '0;
                        if (bus.smode) begin
                            w_state_nxt = WDATA;
                        end else begin
                            w_dren_nxt  = 1'b1;
                            w_state_nxt = MEMRD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (!bus.mvalid) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_wdat_we = 1'b1;
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_cnt_nxt   = '0;
                        w_dwen_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            MEMRD: begin
                // A response landing on the expiry cycle takes priority over the timeout
                if (bus.drvalid) begin
                    w_rdat_ld   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RDATA;
                end else if (w_expire) begin
                    w_rdat_ones = 1'b1;
                    w_dto_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_daddr  <= '0;
            r_dwdata <= '0;
            r_rdat   <= '0;
            r_dwen   <= 1'b0;
            r_dren   <= 1'b0;
            r_dto    <= 1'b0;
        end else begin
            r_dwen <= w_dwen_nxt;
            r_dren <= w_dren_nxt;
            r_dto  <= w_dto_nxt;
            if (w_addr_we) begin
                r_daddr[w_aidx] <= bus.swdata;
            end
            if (w_wdat_we) begin
                r_dwdata[w_didx] <= bus.swdata;
            end
            if (w_rdat_ld) begin
                r_rdat <= bus.drdata;
            end else if (w_rdat_ones) begin
                r_rdat <= '1;
            end
        end
    end

    assign bus.daddr    = r_daddr;
    assign bus.dwdata   = r_dwdata;
    assign bus.dwen     = r_dwen;
    assign bus.dren     = r_dren;
    assign bus.dtimeout = r_dto;
    assign bus.busy     = (r_state != IDLE);
    assign bus.svalid   = (r_state == RDATA);
    assign bus.srdata   = (r_state == RDATA) & r_rdat[w_didx];
endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: expected memory writes, read addresses and serial read words are queued
// as stimulus is driven and popped when the DUT strobes memory or finishes serialising.
module tb_slave_port;
    localparam int AW = 12;
    localparam int DW = 8;
`ifdef SLAVE_PORT_TIMEOUT_EN
    localparam int RD_TO = 10;
`else
    localparam int RD_TO = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slave_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(RD_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_dwen   = 0;
    int n_dren   = 0;
    int n_dto    = 0;

    logic [AW+DW-1:0] q_wr[$];
    logic [AW-1:0]    q_rd_addr[$];
    logic [DW-1:0]    q_rd_dat[$];

    always @(negedge clk) begin
        if (bus.dwen === 1'b1) n_dwen++;
        if (bus.dren === 1'b1) n_dren++;
        if (bus.dtimeout === 1'b1) n_dto++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mvalid  = 1'b0;
        bus.swdata  = 1'b0;
        bus.smode   = 1'b0;
        bus.drvalid = 1'b0;
        bus.drdata  = '0;
    endtask

    task automatic drive_addr(input logic [AW-1:0] a, input logic mode, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.mvalid = 1'b1;
            bus.smode  = mode;
            bus.swdata = a[i];
            step();
        end
    endtask

    task automatic drive_data(input logic [DW-1:0] d);
        for (int i = 0; i < DW; i++) begin
            bus.mvalid = 1'b1;
            bus.swdata = d[i];
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        step();
        step();
        checks++;
        if ({bus.daddr, bus.dwdata, bus.dwen, bus.dren, bus.svalid, bus.srdata, bus.busy, bus.dtimeout} !== '0)
            begin failures++; $display("FAIL reset_outputs: got daddr=%h dwdata=%h busy=%b, expected all zero", bus.daddr, bus.dwdata, bus.busy); end
        rst = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.svalid !== 1'b0)
            begin failures++; $display("FAIL reset_release: busy=%b svalid=%b, expected 0 0", bus.busy, bus.svalid); end
    endtask

    task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w0, r0, waited;
        logic [AW+DW-1:0] exp;
        w0 = n_dwen;
        r0 = n_dren;
        q_wr.push_back({a, d});
        drive_addr(a, 1'b1, AW);
        drive_data(d);
        bus.mvalid = 1'b0;
        waited = 0;
        while (bus.dwen !== 1'b1 && waited < 8) begin step(); waited++; end
        checks++;
        if (waited != 0)
            begin failures++; $display("FAIL wr_latency: dwen after %0d cycles, expected 0", waited); end
        exp = q_wr.pop_front();
        checks++;
        if (bus.dwen !== 1'b1 || {bus.daddr, bus.dwdata} !== exp)
            begin failures++; $display("FAIL wr_data: dwen=%b addr=%h data=%h, expected addr=%h data=%h", bus.dwen, bus.daddr, bus.dwdata, exp[AW+DW-1:DW], exp[DW-1:0]); end
        step();
        checks++;
        if (bus.dwen !== 1'b0 || bus.busy !== 1'b0)
            begin failures++; $display("FAIL wr_pulse: dwen=%b busy=%b after strobe, expected 0 0", bus.dwen, bus.busy); end
        checks++;
        if (n_dwen - w0 != 1 || n_dren != r0)
            begin failures++; $display("FAIL wr_count: dwen pulses=%0d dren pulses=%0d, expected 1 0", n_dwen - w0, n_dren - r0); end
    endtask

    task automatic test_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay, input logic noise);
        int r0, waited;
        logic ok, gap;
        logic [DW-1:0] got;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        r0 = n_dren;
        q_rd_addr.push_back(a);
        q_rd_dat.push_back(d);
        drive_addr(a, 1'b0, AW);
        bus.mvalid = 1'b0;
        waited = 0;
        while (bus.dren !== 1'b1 && waited < 8) begin step(); waited++; end
        exp_a = q_rd_addr.pop_front();
        checks++;
        if (waited != 0 || bus.daddr !== exp_a)
            begin failures++; $display("FAIL rd_strobe: dren after %0d cycles daddr=%h, expected 0 cycles daddr=%h", waited, bus.daddr, exp_a); end
        ok = 1'b1;
        for (int k = 0; k < delay; k++) begin
            if (bus.busy !== 1'b1 || bus.svalid !== 1'b0) ok = 1'b0;
            step();
        end
        checks++;
        if (ok !== 1'b1 || bus.busy !== 1'b1)
            begin failures++; $display("FAIL rd_wait: busy/svalid wrong while waiting %0d cycles for memory", delay); end
        bus.drvalid = 1'b1;
        bus.drdata  = d;
        step();
        bus.drvalid = noise;
        bus.drdata  = ~d;
        gap = 1'b0;
        got = '0;
        for (int i = 0; i < DW; i++) begin
            if (bus.svalid !== 1'b1 || bus.busy !== 1'b1) gap = 1'b1;
            got[i] = bus.srdata;
            step();
        end
        bus.drvalid = 1'b0;
        exp_d = q_rd_dat.pop_front();
        checks++;
        if (gap !== 1'b0)
            begin failures++; $display("FAIL rd_svalid: svalid not high for %0d cycles right after drvalid", DW); end
        checks++;
        if (got !== exp_d)
            begin failures++; $display("FAIL rd_serial: got %h, expected %h", got, exp_d); end
        checks++;
        if (bus.svalid !== 1'b0 || bus.busy !== 1'b0 || n_dren - r0 != 1)
            begin failures++; $display("FAIL rd_end: svalid=%b busy=%b dren pulses=%0d, expected 0 0 1", bus.svalid, bus.busy, n_dren - r0); end
    endtask

    task automatic test_abort();
        int w0, r0;
        w0 = n_dwen;
        r0 = n_dren;
        drive_addr(12'hFA5, 1'b1, 6);
        bus.mvalid = 1'b0;
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0 || n_dwen != w0 || n_dren != r0)
            begin failures++; $display("FAIL abort: busy=%b dwen pulses=%0d dren pulses=%0d, expected 0 0 0", bus.busy, n_dwen - w0, n_dren - r0); end
        test_write(12'h001, 8'hFF);
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = n_dwen;
        drive_addr(12'h3C7, 1'b1, AW);
        for (int i = 0; i < 3; i++) begin
            bus.mvalid = 1'b1;
            bus.swdata = 1'b1;
            step();
        end
        checks++;
        if (bus.busy !== 1'b1)
            begin failures++; $display("FAIL mid_busy: busy=%b in data phase, expected 1", bus.busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.daddr, bus.dwdata, bus.dwen, bus.dren, bus.svalid, bus.srdata, bus.busy, bus.dtimeout} !== '0)
            begin failures++; $display("FAIL mid_reset: daddr=%h dwdata=%h busy=%b, expected all zero", bus.daddr, bus.dwdata, bus.busy); end
        bus.mvalid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (n_dwen != w0 || bus.busy !== 1'b0)
            begin failures++; $display("FAIL mid_nostrobe: dwen pulses=%0d busy=%b, expected 0 0", n_dwen - w0, bus.busy); end
        test_write(12'h7E1, 8'h96);
    endtask

    task automatic test_back_to_back();
        logic [AW+DW-1:0] exp;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] got, exp_d;
        logic gap;
        q_wr.push_back({12'h0F0, 8'h5A});
        drive_addr(12'h0F0, 1'b1, AW);
        drive_data(8'h5A);
        exp = q_wr.pop_front();
        checks++;
        if (bus.dwen !== 1'b1 || bus.busy !== 1'b0 || {bus.daddr, bus.dwdata} !== exp)
            begin failures++; $display("FAIL b2b_wr1: dwen=%b busy=%b addr=%h data=%h, expected 1 0 %h", bus.dwen, bus.busy, bus.daddr, bus.dwdata, exp); end
        q_rd_addr.push_back(12'h9AB);
        q_rd_dat.push_back(8'h81);
        drive_addr(12'h9AB, 1'b0, AW);
        bus.mvalid = 1'b0;
        exp_a = q_rd_addr.pop_front();
        checks++;
        if (bus.dren !== 1'b1 || bus.daddr !== exp_a)
            begin failures++; $display("FAIL b2b_rd: dren=%b daddr=%h, expected 1 %h", bus.dren, bus.daddr, exp_a); end
        bus.drvalid = 1'b1;
        bus.drdata  = 8'h81;
        step();
        bus.drvalid = 1'b0;
        gap = 1'b0;
        got = '0;
        for (int i = 0; i < DW; i++) begin
            if (bus.svalid !== 1'b1) gap = 1'b1;
            got[i] = bus.srdata;
            step();
        end
        exp_d = q_rd_dat.pop_front();
        checks++;
        if (gap !== 1'b0 || got !== exp_d || bus.busy !== 1'b0)
            begin failures++; $display("FAIL b2b_rd_data: gap=%b got=%h busy=%b, expected 0 %h 0", gap, got, bus.busy, exp_d); end
        q_wr.push_back({12'hFFF, 8'h00});
        drive_addr(12'hFFF, 1'b1, AW);
        drive_data(8'h00);
        bus.mvalid = 1'b0;
        exp = q_wr.pop_front();
        checks++;
        if (bus.dwen !== 1'b1 || {bus.daddr, bus.dwdata} !== exp)
            begin failures++; $display("FAIL b2b_wr2: dwen=%b addr=%h data=%h, expected 1 %h", bus.dwen, bus.daddr, bus.dwdata, exp); end
        step();
    endtask

`ifdef SLAVE_PORT_TIMEOUT_EN
    task automatic test_timeout();
        int waited, t0;
        logic [DW-1:0] got, exp_d;
        t0 = n_dto;
        q_rd_dat.push_back('1);
        drive_addr(12'h444, 1'b0, AW);
        bus.mvalid = 1'b0;
        waited = 0;
        while (bus.dtimeout !== 1'b1 && waited < RD_TO + 5) begin step(); waited++; end
        checks++;
        if (waited != RD_TO || bus.svalid !== 1'b1)
            begin failures++; $display("FAIL to_latency: dtimeout after %0d cycles svalid=%b, expected %0d 1", waited, bus.svalid, RD_TO); end
        got = '0;
        for (int i = 0; i < DW; i++) begin
            got[i] = bus.srdata & bus.svalid;
            step();
        end
        exp_d = q_rd_dat.pop_front();
        checks++;
        if (got !== exp_d || n_dto - t0 != 1 || bus.busy !== 1'b0)
            begin failures++; $display("FAIL to_data: got %h pulses=%0d busy=%b, expected %h 1 0", got, n_dto - t0, bus.busy, exp_d); end
    endtask
`endif

    initial begin
        test_reset();
        test_write(12'hA5C, 8'h3B);
        test_read(12'h123, 8'hC6, 0, 1'b0);
        test_read(12'h456, 8'h39, 5, 1'b1);
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef SLAVE_PORT_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (q_wr.size() + q_rd_addr.size() + q_rd_dat.size() != 0)
            begin failures++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_wr.size() + q_rd_addr.size() + q_rd_dat.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/slave_port.md
# slave_port

Serial-bus slave endpoint that sits directly downstream of the bus master port, on the slave side of the single-bit serial bus. It deserialises the LSB-first memory address and, for writes, the write data shifted out by the master. It then issues a single-cycle read or write strobe to the local slave memory. Read data returned by the memory is serialised back to the master under `svalid`.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, slave memory address width (bus address minus 4-bit slave-select field)
- `DATA_WIDTH`, 8, data word width
- `RD_TIMEOUT`, 255, max cycles to wait for `drvalid`; used only when `SLAVE_PORT_TIMEOUT_EN` is defined

Ports:
- `clk` in 1: single clock; all logic rising-edge
- `rst` in 1: reset, asynchronous, active-high
- `swdata` in 1: serial address/write-data bit from the master
- `smode` in 1: 0 = read, 1 = write; sampled with the final address bit
- `mvalid` in 1: `swdata` valid
- `srdata` out 1: serial read-data bit to the master
- `svalid` out 1: `srdata` valid
- `daddr` out `ADDR_WIDTH`: memory address
- `dwdata` out `DATA_WIDTH`: memory write data
- `dwen` out 1: memory write strobe, one cycle
- `dren` out 1: memory read strobe, one cycle
- `drdata` in `DATA_WIDTH`: memory read data
- `drvalid` in 1: `drdata` valid
- `busy` out 1: high whenever state != IDLE
- `dtimeout` out 1: one-cycle pulse on read timeout

## Operation
- States: IDLE, ADDR, WDATA, MEMRD, RDATA. Counter width is `$clog2(max(ADDR_WIDTH, DATA_WIDTH))+1`.
- IDLE, `mvalid`=1:
  - Shift `swdata` into `daddr[0]`, counter=1, go to ADDR.
  - `mvalid`=0: stay.
- ADDR, `mvalid`=1:
  - `daddr[counter] <= swdata`.
  - At counter==`ADDR_WIDTH-1`: counter=0; if `smode`, go to WDATA; else set `dren`, go to MEMRD.
- ADDR, `mvalid`=0: abort to IDLE, no memory access.
- WDATA, `mvalid`=1:
  - `dwdata[counter] <= swdata`.
  - At counter==`DATA_WIDTH-1`: set `dwen`, go to IDLE.
- WDATA, `mvalid`=0: abort to IDLE, no `dwen`.
- MEMRD:
  - `dren` is high only in the first cycle.
  - On `drvalid`=1 (legal in the `dren` cycle itself): latch `drdata` into the shift register, counter=0, go to RDATA.
- RDATA:
  - `srdata` = data bit counter, LSB first; `svalid`=1.
  - After `DATA_WIDTH` cycles: `svalid`=0, go to IDLE.
- `mvalid` is ignored in MEMRD and RDATA.
- `drvalid` is ignored outside MEMRD.
- `daddr`/`dwdata` hold their last value between transactions and change only during shifting.

## Timing
- Reset: all outputs 0, state IDLE, counter 0. Applies asynchronously mid-transaction; an in-flight transaction is dropped with no strobe.
- `dren` is registered: high in the cycle after the edge that samples the final address bit. `daddr` is valid in that cycle.
- `dwen` is registered: high in the cycle after the edge that samples the final data bit. `daddr`/`dwdata` are valid and stable in that cycle.
- Read turnaround:
  - First `svalid` cycle follows the edge that samples `drvalid`.
  - `drvalid` in the `dren` cycle gives minimum latency: last address bit sample → first `svalid` = 2 cycles.
- `svalid` is exactly `DATA_WIDTH` consecutive cycles, never gapped.
- Back-to-back: the state is IDLE in the `dwen` cycle and in the cycle after the last `svalid`. `mvalid` sampled there starts a new transaction.
- Write transaction occupies `ADDR_WIDTH+DATA_WIDTH` `mvalid` cycles.

## Configuration
- `SLAVE_PORT_TIMEOUT_EN` defined:
  - MEMRD counts cycles. If `drvalid` has not arrived after `RD_TIMEOUT` cycles, pulse `dtimeout` one cycle.
  - Load all-ones data and proceed to RDATA normally, so the master never hangs.
  - `drvalid` arriving in the same cycle as expiry wins; no `dtimeout`.
- Not defined: MEMRD waits indefinitely; `dtimeout` tied 0; `RD_TIMEOUT` unused.

## Test plan
- Write: address 0xA5C, data 0x3B, LSB first, `smode`=1, 20 contiguous `mvalid` cycles → one `dwen` cycle with `daddr`=0xA5C, `dwdata`=0x3B; `dren` never high.
- Read: address 0x123, `smode`=0; memory returns 0xC6 with `drvalid` in the `dren` cycle → `dren` one cycle with `daddr`=0x123; 8 `svalid` cycles carrying `srdata` 0,1,1,0,0,0,1,1.
- Read with a memory delay of 5 cycles → `svalid` starts exactly 1 cycle after `drvalid`, `busy` high throughout.
- `mvalid` dropped after 6 address bits, then a full write to 0x001 with data 0xFF → no strobe from the aborted transfer; the following write completes correctly.
- `rst` asserted mid-WDATA → all outputs 0 immediately, no `dwen`; the next write after reset release succeeds.
- With `SLAVE_PORT_TIMEOUT_EN` and `RD_TIMEOUT`=10, `drvalid` never asserted → `dtimeout` pulses after 10 MEMRD cycles, then 8 `svalid` cycles with `srdata`=1.
